// File: rtl/ysyx_25040105_pkg.sv
// Shared definitions for the multi-cycle load/store unit: access sizes,
// exception codes and the FSM state encoding.
package ysyx_25040105_pkg;

   // Access size field of the LS op (log2 of the byte count)
   localparam logic [1:0] LS_SIZE_B = 2'd0;
   localparam logic [1:0] LS_SIZE_H = 2'd1;
   localparam logic [1:0] LS_SIZE_W = 2'd2;
   localparam logic [1:0] LS_SIZE_D = 2'd3;

   // Exception codes reported with a completed op
   localparam logic [1:0] EXC_NONE     = 2'd0;
   localparam logic [1:0] EXC_MISALIGN = 2'd1;
   localparam logic [1:0] EXC_BUS      = 2'd2;
   localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/ysyx_25040105_lsu_lane.sv
// Byte-lane steering for the LSU: store strobe/data shift into the aligned
// bus word, and load byte-lane extract with sign or zero extension.
module ysyx_25040105_lsu_lane
   import ysyx_25040105_pkg::*;
#(
   parameter  int XLEN   = 32,
   localparam int STRB_W = XLEN / 8,
   localparam int OFF_W  = $clog2(STRB_W)
) (
   input  logic [OFF_W-1:0]  st_off,
   input  logic [1:0]        st_size,
   input  logic [XLEN-1:0]   st_wdata,
   input  logic [OFF_W-1:0]  ld_off,
   input  logic [1:0]        ld_size,
   input  logic              ld_unsigned,
   input  logic [XLEN-1:0]   ld_rdata,
   output logic [STRB_W-1:0] st_wstrb,
   output logic [XLEN-1:0]   st_wdata_sh,
   output logic [XLEN-1:0]   ld_data
);

   logic [STRB_W-1:0]       strb_base;
   logic [XLEN-1:0]         ld_shift;
   logic [XLEN-1:0]         ld_left;
   logic signed [XLEN-1:0]  ld_left_s;
   logic signed [XLEN-1:0]  ld_ext_s;
   int                      ld_bits;
   int                      ld_pad;

   // Store side: contiguous strobe of 2^size bytes and data moved to lane st_off
   always_comb begin
      case (st_size)
         LS_SIZE_B: strb_base = STRB_W'(1);
         LS_SIZE_H: strb_base = STRB_W'(3);
         LS_SIZE_W: strb_base = STRB_W'(15);
         default:   strb_base = '1;
      endcase
      st_wstrb    = strb_base << st_off;
      st_wdata_sh = st_wdata << {st_off, 3'b000};
   end

   // Load side: bring lane ld_off down to bit 0, then extend from the access width
   always_comb begin
      ld_shift = ld_rdata >> {ld_off, 3'b000};
      ld_bits  = 8 << ld_size;
      if (ld_bits > XLEN) ld_bits = XLEN;
      ld_pad    = XLEN - ld_bits;
      ld_left   = ld_shift << ld_pad;
      ld_left_s = ld_left;
      ld_ext_s  = ld_left_s >>> ld_pad;
      if (ld_unsigned) ld_data = ld_left >> ld_pad;
      else             ld_data = ld_ext_s;
   end

endmodule

// File: rtl/ysyx_25040105_lsu_mc.sv
// Multi-cycle load/store unit: accepts one op, issues one aligned bus request,
// waits for the response (with optional timeout) and hands the extended result
// plus exception status to writeback.
module ysyx_25040105_lsu_mc
   import ysyx_25040105_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255,
   parameter int TAG_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [XLEN-1:0]   in_base,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic              mem_req_wen,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [XLEN/8-1:0] mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata,
   input  logic              mem_rsp_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_exc,
   output logic [1:0]        out_exc_code
);

   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = $clog2(TIMEOUT + 2);

   lsu_state_t        state, state_nx;
   logic              is_store_q;
   logic              is_unsigned_q;
   logic [1:0]        size_q;
   logic [OFF_W-1:0]  off_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   ea;
   logic [2:0]        align_mask;
   logic              misalign;
   logic              timeout_hit;
   logic [STRB_W-1:0] st_wstrb;
   logic [XLEN-1:0]   st_wdata_sh;
   logic [XLEN-1:0]   ld_data;

   assign ea = in_base + in_imm;
   // 2^size - 1 in three bits; size 3 wraps to 3'b111 which is the doubleword mask
   assign align_mask  = (3'd1 << in_op[1:0]) - 3'd1;
   assign misalign    = ((ea[2:0] & align_mask) != 3'd0) ||
                        ((XLEN == 32) && (in_op[1:0] == LS_SIZE_D));
   // Fires on the TIMEOUT-th WAIT cycle without a response
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   ysyx_25040105_lsu_lane #(.XLEN(XLEN)) u_lane (
      .st_off      (ea[OFF_W-1:0]),
      .st_size     (in_op[1:0]),
      .st_wdata    (in_wdata),
      .ld_off      (off_q),
      .ld_size     (size_q),
      .ld_unsigned (is_unsigned_q),
      .ld_rdata    (mem_rsp_rdata),
      .st_wstrb    (st_wstrb),
      .st_wdata_sh (st_wdata_sh),
      .ld_data     (ld_data)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx      = state;
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = misalign ? ST_DONE : ST_REQ;
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rsp_valid || timeout_hit) state_nx = ST_DONE;
         end
         default: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = ST_IDLE;
         end
      endcase
   end

   // Op capture, request fields, wait counter and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_store_q    <= 1'b0;
         is_unsigned_q <= 1'b0;
         size_q        <= LS_SIZE_B;
         off_q         <= '0;
         cnt_q         <= '0;
         mem_req_addr  <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
         out_data      <= '0;
         out_tag       <= '0;
         out_exc       <= 1'b0;
         out_exc_code  <= EXC_NONE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  is_store_q    <= in_op[3];
                  is_unsigned_q <= in_op[2];
                  size_q        <= in_op[1:0];
                  off_q         <= ea[OFF_W-1:0];
                  mem_req_addr  <= {ea[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                  mem_req_wen   <= in_op[3];
                  mem_req_wdata <= in_op[3] ? st_wdata_sh : '0;
                  mem_req_wstrb <= in_op[3] ? st_wstrb : '0;
                  out_data      <= '0;
                  out_tag       <= in_tag;
                  out_exc       <= misalign;
                  out_exc_code  <= misalign ? EXC_MISALIGN : EXC_NONE;
               end
            end
            ST_REQ: begin
               if (mem_req_ready) cnt_q <= '0;
            end
            ST_WAIT: begin
               if (mem_rsp_valid) begin
                  if (mem_rsp_err) begin
                     out_exc      <= 1'b1;
                     out_exc_code <= EXC_BUS;
                     out_data     <= '0;
                  end else begin
                     out_data <= is_store_q ? '0 : ld_data;
                  end
               end else if (timeout_hit) begin
                  out_exc      <= 1'b1;
                  out_exc_code <= EXC_TIMEOUT;
                  out_data     <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25040105_lsu_mc.sv
// Testbench for ysyx_25040105_lsu_mc: directed vector table, randomized ops
// against a reference model, mid-op reset, and a 64-bit instance sequence.
module tb_ysyx_25040105_lsu_mc;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // 32-bit instance signals
   logic        in_valid = 1'b0, in_ready;
   logic [3:0]  in_op = '0;
   logic [31:0] in_base = '0, in_imm = '0, in_wdata = '0;
   logic [4:0]  in_tag = '0;
   logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;
   logic        out_valid, out_ready = 1'b0, out_exc;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic [1:0]  out_exc_code;

   // 64-bit instance signals
   logic        w_in_valid = 1'b0, w_in_ready;
   logic [3:0]  w_in_op = '0;
   logic [63:0] w_in_base = '0, w_in_imm = '0, w_in_wdata = '0;
   logic [4:0]  w_in_tag = '0;
   logic        w_req_valid, w_req_ready = 1'b0, w_req_wen;
   logic [63:0] w_req_addr, w_req_wdata;
   logic [7:0]  w_req_wstrb;
   logic        w_rsp_valid = 1'b0, w_rsp_err = 1'b0;
   logic [63:0] w_rsp_rdata = '0;
   logic        w_out_valid, w_out_ready = 1'b0, w_out_exc;
   logic [63:0] w_out_data;
   logic [4:0]  w_out_tag;
   logic [1:0]  w_out_exc_code;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ysyx_25040105_lsu_mc #(.XLEN(32), .TIMEOUT(TMO), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_base(in_base), .in_imm(in_imm), .in_wdata(in_wdata), .in_tag(in_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_exc(out_exc), .out_exc_code(out_exc_code)
   );

   ysyx_25040105_lsu_mc #(.XLEN(64), .TIMEOUT(0), .TAG_W(5)) d64 (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
      .in_base(w_in_base), .in_imm(w_in_imm), .in_wdata(w_in_wdata), .in_tag(w_in_tag),
      .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready),
      .mem_req_addr(w_req_addr), .mem_req_wen(w_req_wen),
      .mem_req_wdata(w_req_wdata), .mem_req_wstrb(w_req_wstrb),
      .mem_rsp_valid(w_rsp_valid), .mem_rsp_rdata(w_rsp_rdata), .mem_rsp_err(w_rsp_err),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .out_tag(w_out_tag), .out_exc(w_out_exc), .out_exc_code(w_out_exc_code)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] base;
      logic [31:0] imm;
      logic [31:0] wdata;
      logic [4:0]  tag;
      int          rdy_dly;   // cycles mem_req_ready is held low
      int          rsp_k;     // WAIT cycle (1-based) in which the response is driven
      logic [31:0] rdata;
      logic        err;
      int          ordy_dly;  // cycles out_ready is held low
      logic        req;       // expected: a bus request is made
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wd;
      logic [31:0] data;
      logic        exc;
      logic [1:0]  code;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: derives the expected bus request and result from the op rules
   function automatic vec_t model(input vec_t v);
      logic [31:0] ea;
      logic [63:0] val;
      int sz, nb, off;
      ea  = v.base + v.imm;
      sz  = int'(v.op[1:0]);
      nb  = 1 << sz;
      off = int'(ea % 32'd4);
      v.req   = !((sz == 3) || ((ea % 32'(nb)) != 32'd0));
      v.addr  = ea - 32'(off);
      v.wstrb = '0;
      v.wd    = '0;
      v.data  = '0;
      v.exc   = 1'b0;
      v.code  = 2'd0;
      if (!v.req) begin
         v.exc  = 1'b1;
         v.code = 2'd1;
         return v;
      end
      if (v.op[3]) begin
         for (int i = 0; i < 4; i++) v.wstrb[i] = (i >= off) && (i < off + nb);
         v.wd = v.wdata << (8 * off);
      end
      if (v.rsp_k > TMO) begin
         v.exc  = 1'b1;
         v.code = 2'd3;
      end else if (v.err) begin
         v.exc  = 1'b1;
         v.code = 2'd2;
      end else if (!v.op[3]) begin
         val = (64'(v.rdata) >> (8 * off)) % (64'd1 << (8 * nb));
         if (!v.op[2] && (val >= (64'd1 << (8 * nb - 1)))) val = val - (64'd1 << (8 * nb));
         v.data = val[31:0];
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v, input string nm);
      @(negedge clk);
      chk({nm, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_op = v.op; in_base = v.base; in_imm = v.imm;
      in_wdata = v.wdata; in_tag = v.tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (v.req) begin
         for (int c = 0; c <= v.rdy_dly; c++) begin
            @(negedge clk);
            chk({nm, ".req_valid"}, 64'(mem_req_valid), 64'd1);
            chk({nm, ".req_addr"}, 64'(mem_req_addr), 64'(v.addr));
            chk({nm, ".req_wen"}, 64'(mem_req_wen), 64'(v.op[3]));
            chk({nm, ".req_wstrb"}, 64'(mem_req_wstrb), 64'(v.wstrb));
            if (v.op[3]) chk({nm, ".req_wdata"}, 64'(mem_req_wdata), 64'(v.wd));
            chk({nm, ".in_ready_busy"}, 64'(in_ready), 64'd0);
            if (c == v.rdy_dly) mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
         end
         for (int c = 1; c <= v.rsp_k; c++) begin
            @(negedge clk);
            if (c == v.rsp_k) begin
               mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata; mem_rsp_err = v.err;
            end
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
         end
      end
      for (int c = 0; c <= v.ordy_dly; c++) begin
         @(negedge clk);
         chk({nm, ".out_valid"}, 64'(out_valid), 64'd1);
         chk({nm, ".out_data"}, 64'(out_data), 64'(v.data));
         chk({nm, ".out_tag"}, 64'(out_tag), 64'(v.tag));
         chk({nm, ".out_exc"}, 64'(out_exc), 64'(v.exc));
         chk({nm, ".out_code"}, 64'(out_exc_code), 64'(v.code));
         chk({nm, ".in_ready_done"}, 64'(in_ready), 64'd0);
         chk({nm, ".req_quiet"}, 64'(mem_req_valid), 64'd0);
         if (c == v.ordy_dly) out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
      @(negedge clk);
      chk({nm, ".out_valid_clr"}, 64'(out_valid), 64'd0);
      chk({nm, ".in_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   task automatic run64(input logic [3:0] op, input logic [63:0] base, input logic [63:0] imm,
                        input logic [63:0] rdata, input logic [63:0] addr,
                        input logic [63:0] data, input int ordy, input string nm);
      @(negedge clk);
      chk({nm, ".in_ready_idle"}, 64'(w_in_ready), 64'd1);
      w_in_valid = 1'b1; w_in_op = op; w_in_base = base; w_in_imm = imm;
      w_in_wdata = '0; w_in_tag = 5'd21;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      @(negedge clk);
      chk({nm, ".req_valid"}, 64'(w_req_valid), 64'd1);
      chk({nm, ".req_addr"}, w_req_addr, addr);
      chk({nm, ".req_wstrb"}, 64'(w_req_wstrb), 64'd0);
      w_req_ready = 1'b1;
      @(posedge clk); #1;
      w_req_ready = 1'b0;
      repeat (3) @(negedge clk);
      w_rsp_valid = 1'b1; w_rsp_rdata = rdata;
      @(posedge clk); #1;
      w_rsp_valid = 1'b0;
      for (int c = 0; c <= ordy; c++) begin
         @(negedge clk);
         chk({nm, ".out_valid"}, 64'(w_out_valid), 64'd1);
         chk({nm, ".out_data"}, w_out_data, data);
         chk({nm, ".out_tag"}, 64'(w_out_tag), 64'd21);
         chk({nm, ".out_exc"}, 64'(w_out_exc), 64'd0);
         chk({nm, ".in_ready_done"}, 64'(w_in_ready), 64'd0);
         if (c == ordy) w_out_ready = 1'b1;
         @(posedge clk); #1;
         w_out_ready = 1'b0;
      end
      @(negedge clk);
      chk({nm, ".out_valid_clr"}, 64'(w_out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[11];
      vec_t v;

      tbl[0]  = '{4'b1000, 32'h80000000, 32'd3, 32'h000000AB, 5'd1, 0, 1, 32'h0, 1'b0, 0,
                  1'b1, 32'h80000000, 4'b1000, 32'hAB000000, 32'h0, 1'b0, 2'd0};
      tbl[1]  = '{4'b0001, 32'h80000000, 32'd2, 32'h0, 5'd2, 0, 2, 32'h80011234, 1'b0, 0,
                  1'b1, 32'h80000000, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 2'd0};
      tbl[2]  = '{4'b0101, 32'h80000000, 32'd2, 32'h0, 5'd3, 0, 1, 32'h80011234, 1'b0, 1,
                  1'b1, 32'h80000000, 4'b0000, 32'h0, 32'h00008001, 1'b0, 2'd0};
      tbl[3]  = '{4'b0010, 32'h80000000, 32'd1, 32'h0, 5'd4, 0, 0, 32'h0, 1'b0, 2,
                  1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd1};
      tbl[4]  = '{4'b1010, 32'h80000010, 32'd4, 32'h12345678, 5'd5, 5, 2, 32'hDEADBEEF, 1'b1, 1,
                  1'b1, 32'h80000014, 4'b1111, 32'h12345678, 32'h0, 1'b1, 2'd2};
      tbl[5]  = '{4'b0000, 32'h00000100, 32'hFFFFFFFF, 32'h0, 5'd6, 0, 6, 32'hFF000000, 1'b0, 0,
                  1'b1, 32'h000000FC, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd3};
      tbl[6]  = '{4'b0000, 32'h00000100, 32'hFFFFFFFF, 32'h0, 5'd7, 0, 4, 32'h80000000, 1'b0, 0,
                  1'b1, 32'h000000FC, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 2'd0};
      tbl[7]  = '{4'b0011, 32'h00000000, 32'd8, 32'h0, 5'd8, 0, 0, 32'h0, 1'b0, 0,
                  1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd1};
      tbl[8]  = '{4'b0100, 32'h00002000, 32'd1, 32'h0, 5'd9, 1, 3, 32'h0000C300, 1'b0, 0,
                  1'b1, 32'h00002000, 4'b0000, 32'h0, 32'h000000C3, 1'b0, 2'd0};
      tbl[9]  = '{4'b1001, 32'h00003000, 32'd2, 32'h1234BEEF, 5'd10, 0, 1, 32'h0, 1'b0, 0,
                  1'b1, 32'h00003000, 4'b1100, 32'hBEEF0000, 32'h0, 1'b0, 2'd0};
      tbl[10] = '{4'b0001, 32'h00004000, 32'd3, 32'h0, 5'd11, 0, 0, 32'h0, 1'b0, 0,
                  1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd1};

      // Reset state, checked while reset is still asserted
      repeat (2) @(negedge clk);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.out_data", 64'(out_data), 64'd0);
      chk("rst.out_tag", 64'(out_tag), 64'd0);
      chk("rst.out_exc", 64'(out_exc), 64'd0);
      chk("rst.out_code", 64'(out_exc_code), 64'd0);
      chk("rst.req_addr", 64'(mem_req_addr), 64'd0);
      chk("rst.req_wstrb", 64'(mem_req_wstrb), 64'd0);
      chk("rst.w_in_ready", 64'(w_in_ready), 64'd1);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_op(tbl[i], $sformatf("vec%0d", i));

      // Reset in the middle of WAIT aborts the op; the late response is ignored
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'b0010; in_base = 32'h500; in_imm = 32'h0; in_tag = 5'd17;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("midrst.req_valid", 64'(mem_req_valid), 64'd1);
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst.in_ready", 64'(in_ready), 64'd1);
      chk("midrst.req_valid0", 64'(mem_req_valid), 64'd0);
      chk("midrst.out_valid", 64'(out_valid), 64'd0);
      chk("midrst.out_tag", 64'(out_tag), 64'd0);
      chk("midrst.req_addr", 64'(mem_req_addr), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("midrst.late_out_valid", 64'(out_valid), 64'd0);
      chk("midrst.late_in_ready", 64'(in_ready), 64'd1);
      chk("midrst.late_out_data", 64'(out_data), 64'd0);

      // Randomized ops against the reference model
      for (int i = 0; i < 60; i++) begin
         logic [31:0] m;
         v.op    = 4'($urandom);
         v.base  = $urandom & 32'hFFFFFFF0;
         v.imm   = 32'($urandom_range(0, 15));
         m       = (32'd1 << v.op[1:0]) - 32'd1;
         if ($urandom_range(0, 2) != 0) v.imm = v.imm & ~m;
         v.wdata   = $urandom;
         v.tag     = 5'($urandom);
         v.rdy_dly = $urandom_range(0, 3);
         v.rsp_k   = $urandom_range(1, 6);
         v.rdata   = $urandom;
         v.err     = ($urandom_range(0, 7) == 0);
         v.ordy_dly = $urandom_range(0, 2);
         v = model(v);
         run_op(v, $sformatf("rnd%0d", i));
      end

      // 64-bit instance: doubleword, signed word at lane 4, unsigned byte at lane 7
      run64(4'b0011, 64'h8000_0000_0000_0000, 64'd8, 64'h0123_4567_89AB_CDEF,
            64'h8000_0000_0000_0008, 64'h0123_4567_89AB_CDEF, 3, "x64_ld");
      run64(4'b0010, 64'h1000, 64'd4, 64'h8000_0001_0000_0000,
            64'h1000, 64'hFFFF_FFFF_8000_0001, 0, "x64_lw");
      run64(4'b0100, 64'h2000, 64'd7, 64'hA500_0000_0000_0000,
            64'h2000, 64'h0000_0000_0000_00A5, 1, "x64_lbu");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
